// File: rtl/eth_rx_header_reader.sv
// Ethernet RX header reader: once armed, captures one frame header (dest MAC,
// src MAC, EtherType), optionally drains the payload while counting bytes, and
// holds the captured fields with a level valid until re-armed.
module eth_rx_header_reader #(
    parameter int unsigned LEN_WIDTH     = 16,
    parameter bit          DRAIN_PAYLOAD = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 start,

    input  logic                 s_eth_hdr_valid,
    output logic                 s_eth_hdr_ready,
    input  logic [47:0]          s_eth_dest_mac,
    input  logic [47:0]          s_eth_src_mac,
    input  logic [15:0]          s_eth_type,

    input  logic [7:0]           s_eth_payload_axis_tdata,
    input  logic                 s_eth_payload_axis_tvalid,
    input  logic                 s_eth_payload_axis_tlast,
    input  logic                 s_eth_payload_axis_tuser,
    output logic                 s_eth_payload_axis_tready,

    output logic                 busy,
    output logic                 valid,
    output logic [47:0]          dest_mac,
    output logic [47:0]          src_mac,
    output logic [15:0]          eth_type,
    output logic [LEN_WIDTH-1:0] payload_len,
    output logic                 payload_err
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitHdr = 2'd1,
        StDrain   = 2'd2,
        StDone    = 2'd3
    } state_e;

    localparam logic [LEN_WIDTH-1:0] LenMax = '1;
    localparam logic [LEN_WIDTH-1:0] LenOne = LEN_WIDTH'(1);

    state_e state;

    // Payload bytes are only counted, never stored.
    logic unused_tdata;
    assign unused_tdata = ^s_eth_payload_axis_tdata;

    // Handshakes and status decode the state; gating by rst keeps a reset cycle from
    // accepting anything.
    always_comb begin
        s_eth_hdr_ready           = (state == StWaitHdr) && !rst;
        s_eth_payload_axis_tready = (state == StDrain) && !rst;
        busy                      = ((state == StWaitHdr) || (state == StDrain)) && !rst;
        valid                     = (state == StDone) && !rst;
    end

    // Control FSM plus captured fields and payload counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            dest_mac    <= '0;
            src_mac     <= '0;
            eth_type    <= '0;
            payload_len <= '0;
            payload_err <= 1'b0;
        end else begin
            unique case (state)
                StIdle, StDone: begin
                    // Re-arm keeps the old header fields until the next capture.
                    if (start) begin
                        state       <= StWaitHdr;
                        payload_len <= '0;
                        payload_err <= 1'b0;
                    end
                end
                StWaitHdr: begin
                    if (s_eth_hdr_valid) begin
                        dest_mac <= s_eth_dest_mac;
                        src_mac  <= s_eth_src_mac;
                        eth_type <= s_eth_type;
                        state    <= DRAIN_PAYLOAD ? StDrain : StDone;
                    end
                end
                StDrain: begin
                    if (s_eth_payload_axis_tvalid) begin
                        // Saturate rather than wrap on oversized frames.
                        if (payload_len != LenMax) begin
                            payload_len <= payload_len + LenOne;
                        end
                        if (s_eth_payload_axis_tlast) begin
                            payload_err <= s_eth_payload_axis_tuser;
                            state       <= StDone;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
